req_queue_1r1w: RTL and testbench
=================================

// Module: req_queue_1r1w
// PURPOSE
//  Ingress request queue that sits directly upstream of the 1R1W virtual-bank memory core.
//  Accepts one client write and/or one client read per cycle under a valid/ready handshake.
//  Buffers each cycle's pair as a single entry in a FIFO, so program order is preserved.
//  Replays entries to the core's vwrite/vread ports only once the core reports ready.
//  Drops out-of-range addresses and flags handshake and address violations.
// PARAMETERS
//  WIDTH      32    data width
//  BITADDR    13    address width
//  NUMADDR    8192  legal address count; valid addresses are 0..NUMADDR-1
//  FIFO_DEPTH 4     queue entries (power of two, >=2)
//  BITFIFO    2     log2(FIFO_DEPTH)
// PORTS
//  clk       in   1            clock
//  rst       in   1            asynchronous reset, active-low (0 = reset)
//  cwrite    in   1            client write request
//  cwraddr   in   BITADDR      client write address
//  cdin      in   WIDTH        client write data
//  cread     in   1            client read request
//  crdaddr   in   BITADDR      client read address
//  cready    out  1            queue can accept a request this cycle
//  core_rdy  in   1            core's ready output (its reset/init sweep is complete)
//  vwrite    out  1            write to core (registered)
//  vwraddr   out  BITADDR      write address to core
//  vdin      out  WIDTH        write data to core
//  vread     out  1            read to core (registered)
//  vrdaddr   out  BITADDR      read address to core
//  fifo_cnt  out  BITFIFO+1    current occupancy
//  ovf_err   out  1            sticky: request presented while cready=0
//  addr_err  out  1            sticky: request address >= NUMADDR
// BEHAVIOUR
//  - Reset (rst=0, async): pointers=0, fifo_cnt=0, all v* outputs=0, ovf_err=0, addr_err=0.
//    FIFO data contents are don't-care.
//  - cready = (fifo_cnt < FIFO_DEPTH); it is combinational from the registered count only.
//  - Push: when (cwrite|cread) & cready, write entry {wr,wraddr,din,rd,rdaddr} at wptr; wptr++.
//  - Range check: a leg whose address is >= NUMADDR has its valid bit cleared in the entry.
//    That leg also sets addr_err. If both legs are invalid, nothing is pushed.
//  - Overflow: (cwrite|cread) & !cready sets ovf_err. The request is discarded and the state
//    is otherwise unchanged.
//  - Pop: when core_rdy & fifo_cnt!=0, the head loads the output register next edge; rptr++.
//    vwrite/vread take the stored valid bits.
//  - When there is no pop, vwrite=vread=0 next cycle; addresses and data hold their last values.
//  - Simultaneous push and pop: count unchanged. A push into an empty queue cannot pop in the
//    same cycle (no bypass).
//  - Latency: push at edge t -> appears on v* after edge t+1 (2 cycles), provided core_rdy=1.
//  - Throughput: one entry per cycle sustained while core_rdy=1.
//  - When full, push is refused even if a pop occurs that cycle (cready uses the registered count).
//  - Pointer wrap: modulo FIFO_DEPTH; fifo_cnt ranges 0..FIFO_DEPTH.
//  - core_rdy low (core init or core reset) stalls issue; the queue keeps its contents and
//    continues accepting until full.
//  - A write and a read in one entry are issued in the same cycle. Same-address write/read
//    semantics in that case are the core's; the queue never reorders entries.
//  - ovf_err and addr_err clear only on reset.
// TESTING
//  1) Reset with rst=0 mid-traffic (fifo_cnt=3) -> fifo_cnt=0, vwrite=vread=0, errs=0
//     immediately, with no clock edge needed.
//  2) core_rdy=1, cwrite addr 0x0A5 din 0xDEADBEEF at t -> vwrite=1, vwraddr=0x0A5,
//     vdin=0xDEADBEEF after edge t+1, for one cycle only.
//  3) core_rdy=0, push 5 writes (addr 1..5) -> cready=0 after 4, fifo_cnt=4, 5th sets ovf_err.
//     Then core_rdy=1 -> addrs 1,2,3,4 issued on consecutive cycles.
//  4) Same-cycle cwrite 0x10 + cread 0x10 -> single entry; vwrite=vread=1 in the same cycle,
//     both addresses 0x10.
//  5) cread crdaddr=8192 with cwrite 0x20 -> only vwrite issued, addr_err=1.
//     A lone cread 8200 -> no push, fifo_cnt unchanged.
//  6) Full queue with core_rdy=1 and continuous client requests -> fifo_cnt settles to 3/4.
//     No entry is lost or duplicated; order matches the push order over 100 random entries.

Source files
------------

// File: rtl/req_queue_1r1w.sv
// req_queue_1r1w
//   Ingress request queue in front of the 1R1W virtual-bank memory core.
//   Each cycle's client write and/or read is packed into one FIFO entry, so
//   program order is kept. Entries are replayed to the core's vwrite/vread
//   ports only while the core reports ready. Out-of-range legs are dropped,
//   and handshake/address violations are flagged with sticky error bits.
//
// Ports
//   clk, rst                 clock, async active-low reset
//   cwrite/cwraddr/cdin      client write leg
//   cread/crdaddr            client read leg
//   cready                   queue can take a request this cycle
//   core_rdy                 core init sweep complete, issue allowed
//   vwrite/vwraddr/vdin      registered write to core
//   vread/vrdaddr            registered read to core
//   fifo_cnt                 occupancy, 0..FIFO_DEPTH
//   ovf_err                  sticky: request while cready=0
//   addr_err                 sticky: accepted request had an address >= NUMADDR
module req_queue_1r1w #(
  parameter int WIDTH      = 32,
  parameter int BITADDR    = 13,
  parameter int NUMADDR    = 8192,
  parameter int FIFO_DEPTH = 4,
  parameter int BITFIFO    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cwrite,
  input  logic [BITADDR-1:0] cwraddr,
  input  logic [WIDTH-1:0]   cdin,
  input  logic               cread,
  input  logic [BITADDR-1:0] crdaddr,
  output logic               cready,
  input  logic               core_rdy,
  output logic               vwrite,
  output logic [BITADDR-1:0] vwraddr,
  output logic [WIDTH-1:0]   vdin,
  output logic               vread,
  output logic [BITADDR-1:0] vrdaddr,
  output logic [BITFIFO:0]   fifo_cnt,
  output logic               ovf_err,
  output logic               addr_err
);

  typedef struct packed {
    logic               wr;
    logic [BITADDR-1:0] wraddr;
    logic [WIDTH-1:0]   din;
    logic               rd;
    logic [BITADDR-1:0] rdaddr;
  } entry_t;

  localparam logic [BITFIFO:0] DEPTH_C = (BITFIFO+1)'(FIFO_DEPTH);

  entry_t             mem [FIFO_DEPTH];
  logic [BITFIFO-1:0] wptr, rptr;
  logic               wr_ok, rd_ok, req, push, pop;
  entry_t             new_ent, head;

  // Compare in 32 bits so the check stays meaningful when NUMADDR == 2**BITADDR.
  function automatic logic in_range(input logic [BITADDR-1:0] a);
    int unsigned ai;
    ai = 32'(a);
    return ai < 32'(NUMADDR);
  endfunction

  // cready looks only at the registered count: a full queue refuses a push
  // even in a cycle where it also pops.
  assign cready = (fifo_cnt < DEPTH_C);
  assign req    = cwrite | cread;
  assign wr_ok  = cwrite & in_range(cwraddr);
  assign rd_ok  = cread  & in_range(crdaddr);
  assign push   = cready & (wr_ok | rd_ok);
  assign pop    = core_rdy & (fifo_cnt != '0);

  assign new_ent = '{wr: wr_ok, wraddr: cwraddr, din: cdin, rd: rd_ok, rdaddr: crdaddr};
  assign head    = mem[rptr];

  // Storage needs no reset; only the pointers/count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= new_ent;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      fifo_cnt <= '0;
      ovf_err  <= 1'b0;
      addr_err <= 1'b0;
      vwrite   <= 1'b0;
      vread    <= 1'b0;
      vwraddr  <= '0;
      vrdaddr  <= '0;
      vdin     <= '0;
    end else begin
      if (push) wptr <= wptr + BITFIFO'(1);
      if (pop)  rptr <= rptr + BITFIFO'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (BITFIFO+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (BITFIFO+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      // A refused request leaves everything but ovf_err untouched, so the
      // range flag is only raised for requests the queue actually took.
      if (req & ~cready) ovf_err <= 1'b1;
      if (cready & ((cwrite & ~wr_ok) | (cread & ~rd_ok))) addr_err <= 1'b1;
      // Strobes pulse for one cycle per pop; address/data hold otherwise.
      if (pop) begin
        vwrite  <= head.wr;
        vread   <= head.rd;
        vwraddr <= head.wraddr;
        vrdaddr <= head.rdaddr;
        vdin    <= head.din;
      end else begin
        vwrite <= 1'b0;
        vread  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_req_queue_1r1w.sv
// Bench for req_queue_1r1w: directed scenarios plus random traffic, checked
// every cycle against a queue-based reference model.
module tb_req_queue_1r1w;
  localparam int W  = 32;
  localparam int AW = 14;   // wide enough to present addresses >= NUMADDR
  localparam int NA = 8192;
  localparam int D  = 4;
  localparam int BF = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cwrite, cread, core_rdy;
  logic [AW-1:0] cwraddr, crdaddr;
  logic [W-1:0]  cdin;
  logic          cready, vwrite, vread, ovf_err, addr_err;
  logic [AW-1:0] vwraddr, vrdaddr;
  logic [W-1:0]  vdin;
  logic [BF:0]   fifo_cnt;

  req_queue_1r1w #(.WIDTH(W), .BITADDR(AW), .NUMADDR(NA), .FIFO_DEPTH(D), .BITFIFO(BF)) dut (
    .clk(clk), .rst(rst),
    .cwrite(cwrite), .cwraddr(cwraddr), .cdin(cdin),
    .cread(cread), .crdaddr(crdaddr),
    .cready(cready), .core_rdy(core_rdy),
    .vwrite(vwrite), .vwraddr(vwraddr), .vdin(vdin),
    .vread(vread), .vrdaddr(vrdaddr),
    .fifo_cnt(fifo_cnt), .ovf_err(ovf_err), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [AW-1:0] wa;
    logic [W-1:0]  din;
    logic          rd;
    logic [AW-1:0] ra;
  } ent_t;

  ent_t          q[$];
  logic          e_vw, e_vr, e_ovf, e_aerr;
  logic [AW-1:0] e_wa, e_ra;
  logic [W-1:0]  e_din;
  int            n_chk = 0;
  int            n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    e_vw = 0; e_vr = 0; e_wa = '0; e_ra = '0; e_din = '0; e_ovf = 0; e_aerr = 0;
  endtask

  task automatic check_all();
    chk("vwrite",   vwrite,   e_vw);
    chk("vread",    vread,    e_vr);
    chk("vwraddr",  vwraddr,  e_wa);
    chk("vrdaddr",  vrdaddr,  e_ra);
    chk("vdin",     vdin,     e_din);
    chk("fifo_cnt", fifo_cnt, q.size());
    chk("ovf_err",  ovf_err,  e_ovf);
    chk("addr_err", addr_err, e_aerr);
  endtask

  // One clock cycle: drive, check cready, clock, advance model, check outputs.
  task automatic cyc(input logic cw, input logic [AW-1:0] wa, input logic [W-1:0] din,
                     input logic cr, input logic [AW-1:0] ra, input logic crdy);
    bit   full, wv, rv;
    ent_t e;
    cwrite = cw; cwraddr = wa; cdin = din; cread = cr; crdaddr = ra; core_rdy = crdy;
    full = (q.size() >= D);
    #1 chk("cready", cready, !full);
    @(posedge clk); #1;
    if (crdy && q.size() != 0) begin
      e = q.pop_front();
      e_vw = e.wr; e_vr = e.rd; e_wa = e.wa; e_ra = e.ra; e_din = e.din;
    end else begin
      e_vw = 0; e_vr = 0;
    end
    wv = cw && (int'(wa) < NA);
    rv = cr && (int'(ra) < NA);
    if (cw || cr) begin
      if (full) e_ovf = 1;
      else begin
        if ((cw && !wv) || (cr && !rv)) e_aerr = 1;
        if (wv || rv) q.push_back('{wr: wv, wa: wa, din: din, rd: rv, ra: ra});
      end
    end
    check_all();
  endtask

  task automatic idle(input logic crdy);
    cyc(0, '0, '0, 0, '0, crdy);
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 15) == 0) return AW'(NA + $urandom_range(0, 2000));
    return AW'($urandom_range(0, NA - 1));
  endfunction

  initial begin
    cwrite = 0; cread = 0; cwraddr = '0; crdaddr = '0; cdin = '0; core_rdy = 0;
    rst = 0;
    model_clear();
    #1;
    chk("rst_cnt", fifo_cnt, 0);
    chk("rst_vw",  vwrite,   0);
    chk("rst_ovf", ovf_err,  0);
    @(negedge clk); rst = 1;

    // Single write, two-cycle latency, one-cycle pulse
    cyc(1, AW'('h0A5), 32'hDEADBEEF, 0, '0, 1);
    chk("t2_not_yet", vwrite, 0);
    idle(1);
    chk("t2_vw",   vwrite,  1);
    chk("t2_addr", vwraddr, 'h0A5);
    chk("t2_din",  vdin,    32'hDEADBEEF);
    idle(1);
    chk("t2_pulse", vwrite, 0);

    // Paired write+read in one entry
    cyc(1, AW'('h10), 32'h1234_5678, 1, AW'('h10), 1);
    chk("t4_cnt", fifo_cnt, 1);
    idle(1);
    chk("t4_vw", vwrite, 1);
    chk("t4_vr", vread, 1);
    chk("t4_wa", vwraddr, 'h10);
    chk("t4_ra", vrdaddr, 'h10);

    // Stall while core not ready, overflow, then drain in order
    for (int i = 1; i <= 5; i++) begin
      cyc(1, AW'(i), 32'(i * 100), 0, '0, 0);
      if (i == 4) begin
        chk("t3_cready", cready, 0);
        chk("t3_full", fifo_cnt, 4);
      end
    end
    chk("t3_ovf", ovf_err, 1);
    for (int i = 1; i <= 4; i++) begin
      idle(1);
      chk("t3_vw", vwrite, 1);
      chk("t3_order", vwraddr, i);
    end
    idle(1);
    chk("t3_empty", fifo_cnt, 0);

    // Out-of-range read leg dropped; lone out-of-range read not pushed
    cyc(1, AW'('h20), 32'hCAFE_0001, 1, AW'(8192), 1);
    chk("t5_aerr", addr_err, 1);
    idle(1);
    chk("t5_vw", vwrite, 1);
    chk("t5_vr", vread, 0);
    chk("t5_wa", vwraddr, 'h20);
    cyc(0, '0, '0, 1, AW'(8200), 1);
    chk("t5_nopush", fifo_cnt, 0);

    // Async reset mid-traffic with three entries queued
    for (int i = 0; i < 3; i++) cyc(1, rnd_addr(), $urandom, 1, rnd_addr(), 0);
    idle(0);
    chk("t1_pre", fifo_cnt, q.size());
    #2 rst = 0;
    #1;
    chk("t1_cnt",  fifo_cnt, 0);
    chk("t1_vw",   vwrite,   0);
    chk("t1_vr",   vread,    0);
    chk("t1_ovf",  ovf_err,  0);
    chk("t1_aerr", addr_err, 0);
    chk("t1_wa",   vwraddr,  0);
    model_clear();
    @(negedge clk); rst = 1;

    // Full queue released with continuous requests: settles at 3
    for (int i = 0; i < 4; i++) cyc(1, AW'($urandom_range(0, NA - 1)), $urandom, 0, '0, 0);
    for (int i = 0; i < 100; i++) begin
      cyc(1, AW'($urandom_range(0, NA - 1)), $urandom, $urandom_range(0, 1), rnd_addr(), 1);
      if (i == 3) chk("t6_settle", fifo_cnt, 3);
    end

    // Random traffic with random core readiness
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 2) != 0, rnd_addr(), $urandom, $urandom_range(0, 1), rnd_addr(),
          $urandom_range(0, 3) != 0);
    for (int i = 0; i < 6; i++) idle(1);
    chk("drain", fifo_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
